alu_in_driver: RTL and testbench

- Synthesizable transmitter for the ALU input interface (iAluIn side).
- Accepts ALU operation transactions from a hardware stimulus source over a valid/ready handshake and buffers them in a small FIFO.
- Applies an optional per-transaction idle delay, then drives each operation onto the ALU input pins with the ACT/ALU_RDY handshake.
- Sits between the FPGA-side generator and the ALU DUT in the accelerated verification environment.

---
 rtl/alu_in_driver.sv | 205 ++++++++++++++++++++
 tb/tb_alu_in_driver.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_in_driver.sv
// alu_in_driver: buffers ALU operation transactions from a valid/ready source
// in a small FIFO, waits out each transaction's idle delay, then presents it
// on the ALU input pins with the ACT/ALU_RDY handshake.
// Optional build macro: ALU_IN_DRIVER_STATS_EN adds stall_cnt and max_fill.
module alu_in_driver #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int DELAY_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [3:0]             in_op,
  input  logic [1:0]             in_movi,
  input  logic [DATA_WIDTH-1:0]  in_reg_a,
  input  logic [DATA_WIDTH-1:0]  in_reg_b,
  input  logic [DATA_WIDTH-1:0]  in_mem,
  input  logic [DATA_WIDTH-1:0]  in_imm,
  input  logic [DELAY_WIDTH-1:0] in_delay,
  output logic                   ACT,
  output logic [3:0]             OP,
  output logic [1:0]             MOVI,
  output logic [DATA_WIDTH-1:0]  REG_A,
  output logic [DATA_WIDTH-1:0]  REG_B,
  output logic [DATA_WIDTH-1:0]  MEM,
  output logic [DATA_WIDTH-1:0]  IMM,
  input  logic                   ALU_RDY,
  output logic                   busy,
  output logic [15:0]            sent_cnt
`ifdef ALU_IN_DRIVER_STATS_EN
  ,
  output logic [15:0]                   stall_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   max_fill
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int ENT_W = 4 + 2 + 4 * DATA_WIDTH + DELAY_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Output-side state
  logic [1:0]             r_state;
  logic                   r_act;
  logic [DELAY_WIDTH-1:0] r_dly;
  logic [3:0]             r_op;
  logic [1:0]             r_movi;
  logic [DATA_WIDTH-1:0]  r_reg_a;
  logic [DATA_WIDTH-1:0]  r_reg_b;
  logic [DATA_WIDTH-1:0]  r_mem_op;
  logic [DATA_WIDTH-1:0]  r_imm;
  logic [15:0]            r_sent;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_fire;
  logic [CW-1:0]          w_count_nxt;
  logic [ENT_W-1:0]       w_wr_ent;
  logic [ENT_W-1:0]       w_head;
  logic [3:0]             w_head_op;
  logic [1:0]             w_head_movi;
  logic [DATA_WIDTH-1:0]  w_head_a;
  logic [DATA_WIDTH-1:0]  w_head_b;
  logic [DATA_WIDTH-1:0]  w_head_mem;
  logic [DATA_WIDTH-1:0]  w_head_imm;
  logic [DELAY_WIDTH-1:0] w_head_dly;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // Ready comes only from registered occupancy: a full FIFO never accepts,
  // even when the head leaves on the same edge.
  assign in_rdy  = RST & ~w_full;
  assign w_push  = in_vld & in_rdy;

  // The head is taken whenever the output stage is free: idle, or finishing
  // a transfer this edge.
  assign w_fire  = r_act & ALU_RDY;
  assign w_pop   = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_ISSUE) & ALU_RDY));

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign w_wr_ent = {in_op, in_movi, in_reg_a, in_reg_b, in_mem, in_imm, in_delay};
  assign w_head   = r_mem[r_rd_ptr];
  assign {w_head_op, w_head_movi, w_head_a, w_head_b, w_head_mem, w_head_imm, w_head_dly} = w_head;

  // FIFO payload write; contents need no reset since the pointers gate them
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_ent;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  // Issue FSM: load head, count down idle delay, hold ACT until accepted
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_act    <= 1'b0;
      r_dly    <= '0;
      r_op     <= '0;
      r_movi   <= '0;
      r_reg_a  <= '0;
      r_reg_b  <= '0;
      r_mem_op <= '0;
      r_imm    <= '0;
      r_sent   <= '0;
    end else begin
      if (w_fire) r_sent <= r_sent + 16'd1;
      if (w_pop) begin
        r_op     <= w_head_op;
        r_movi   <= w_head_movi;
        r_reg_a  <= w_head_a;
        r_reg_b  <= w_head_b;
        r_mem_op <= w_head_mem;
        r_imm    <= w_head_imm;
        r_dly    <= w_head_dly;
        if (w_head_dly == '0) begin
          r_state <= S_ISSUE;
          r_act   <= 1'b1;
        end else begin
          r_state <= S_WAIT;
          r_act   <= 1'b0;
        end
      end else begin
        case (r_state)
          S_WAIT: begin
            // The edge that sees 1 is the last idle one; ACT rises with it.
            if (r_dly == DELAY_WIDTH'(1)) begin
              r_state <= S_ISSUE;
              r_act   <= 1'b1;
              r_dly   <= '0;
            end else begin
              r_dly <= r_dly - DELAY_WIDTH'(1);
            end
          end
          S_ISSUE: begin
            if (ALU_RDY) begin
              r_state <= S_IDLE;
              r_act   <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_act   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ACT      = r_act;
  assign OP       = r_op;
  assign MOVI     = r_movi;
  assign REG_A    = r_reg_a;
  assign REG_B    = r_reg_b;
  assign MEM      = r_mem_op;
  assign IMM      = r_imm;
  assign sent_cnt = r_sent;
  assign busy     = ~w_empty | (r_state != S_IDLE);

`ifdef ALU_IN_DRIVER_STATS_EN
  logic [15:0] r_stall;
  logic [CW-1:0] r_max;

  // Stall counter and peak-occupancy tracker
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_stall <= '0;
      r_max   <= '0;
    end else begin
      if (r_act && !ALU_RDY) r_stall <= r_stall + 16'd1;
      if (w_count_nxt > r_max) r_max <= w_count_nxt;
    end
  end

  assign stall_cnt = r_stall;
  assign max_fill  = r_max;
`endif

endmodule

// File: tb/tb_alu_in_driver.sv
// Bench for alu_in_driver: transaction-level queue model plus directed
// literal checks, randomized traffic and a sent_cnt wrap run.
module tb_alu_in_driver;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DLW   = 8;

  logic CLK = 1'b0;
  logic RST;
  logic in_vld;
  logic in_rdy;
  logic [3:0] in_op;
  logic [1:0] in_movi;
  logic [DW-1:0] in_reg_a, in_reg_b, in_mem, in_imm;
  logic [DLW-1:0] in_delay;
  logic ACT;
  logic [3:0] OP;
  logic [1:0] MOVI;
  logic [DW-1:0] REG_A, REG_B, MEM, IMM;
  logic ALU_RDY;
  logic busy;
  logic [15:0] sent_cnt;
`ifdef ALU_IN_DRIVER_STATS_EN
  logic [15:0] stall_cnt;
  logic [$clog2(DEPTH):0] max_fill;
`endif

  always #5 CLK = ~CLK;

  alu_in_driver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DELAY_WIDTH(DLW)) dut (
    .CLK(CLK), .RST(RST), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_op(in_op), .in_movi(in_movi), .in_reg_a(in_reg_a), .in_reg_b(in_reg_b),
    .in_mem(in_mem), .in_imm(in_imm), .in_delay(in_delay),
    .ACT(ACT), .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B),
    .MEM(MEM), .IMM(IMM), .ALU_RDY(ALU_RDY), .busy(busy), .sent_cnt(sent_cnt)
`ifdef ALU_IN_DRIVER_STATS_EN
    , .stall_cnt(stall_cnt), .max_fill(max_fill)
`endif
  );

  typedef struct packed {
    logic [3:0]     op;
    logic [1:0]     movi;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [DW-1:0]  mem;
    logic [DW-1:0]  imm;
    logic [DLW-1:0] dly;
  } txn_t;

  // Reference model: pending queue, one "current" transaction at the pins
  txn_t        q[$];
  txn_t        cur;
  bit          m_have, m_act, m_live;
  int          m_wait;
  logic [15:0] m_sent;
  int          m_stall;
  int          m_max;
  int          m_pushes;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  initial begin
    txn_t t;
    bit rdy, push, fire;
    m_live = 0; m_have = 0; m_act = 0; m_wait = 0; m_sent = 0; cur = '0;
    m_stall = 0; m_max = 0; m_pushes = 0;
    forever begin
      @(posedge CLK);
      if (!RST) begin
        q.delete();
        m_have = 0; m_act = 0; m_wait = 0; m_sent = 0; cur = '0;
        m_stall = 0; m_max = 0; m_pushes = 0; m_live = 1;
      end else begin
        rdy  = (q.size() < DEPTH);
        push = in_vld && rdy;
        fire = m_act && ALU_RDY;
        t = '{op: in_op, movi: in_movi, a: in_reg_a, b: in_reg_b,
              mem: in_mem, imm: in_imm, dly: in_delay};
        if (m_act && !ALU_RDY) m_stall = m_stall + 1;
        if (fire) m_sent = m_sent + 16'd1;
        if ((!m_have || fire) && q.size() > 0) begin
          cur    = q.pop_front();
          m_have = 1;
          m_wait = int'(cur.dly);
          m_act  = (m_wait == 0);
        end else if (fire) begin
          m_have = 0;
          m_act  = 0;
        end else if (m_have && !m_act) begin
          m_wait = m_wait - 1;
          if (m_wait == 0) m_act = 1;
        end
        if (push) begin
          q.push_back(t);
          m_pushes = m_pushes + 1;
        end
        if (q.size() > m_max) m_max = q.size();
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge CLK) begin
    if (m_live) begin
      chk("act", ACT, m_act);
      chk("in_rdy", in_rdy, RST && (q.size() < DEPTH));
      chk("busy", busy, (q.size() > 0) || m_have);
      chk("sent_cnt", sent_cnt, m_sent);
      chk("data", {OP, MOVI, REG_A, REG_B, MEM, IMM},
          {cur.op, cur.movi, cur.a, cur.b, cur.mem, cur.imm});
`ifdef ALU_IN_DRIVER_STATS_EN
      chk("stall_cnt", stall_cnt, 16'(m_stall));
      chk("max_fill", max_fill, m_max);
`endif
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_txn(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] d);
    in_op    = op;
    in_movi  = 2'($urandom);
    in_reg_a = a;
    in_reg_b = b;
    in_mem   = 8'($urandom);
    in_imm   = 8'($urandom);
    in_delay = d;
  endtask

  initial begin
    int cyc;
    RST = 0; in_vld = 0; ALU_RDY = 0;
    set_txn(4'd0, 8'd0, 8'd0, 8'd0);
    step(); step(); step();
    chk("reset act", ACT, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset sent", sent_cnt, 16'd0);
    chk("reset in_rdy", in_rdy, 1'b0);
    chk("reset op", OP, 4'd0);
    RST = 1;
    step();

    // Single transaction, no delay, ALU always ready
    ALU_RDY = 1;
    set_txn(4'd1, 8'h05, 8'h03, 8'd0);
    in_vld = 1;
    step();
    in_vld = 0;
    chk("t1 act after push", ACT, 1'b0);
    chk("t1 busy after push", busy, 1'b1);
    step();
    chk("t1 act", ACT, 1'b1);
    chk("t1 op", OP, 4'd1);
    chk("t1 reg_a", REG_A, 8'h05);
    chk("t1 reg_b", REG_B, 8'h03);
    step();
    chk("t1 act drop", ACT, 1'b0);
    chk("t1 sent", sent_cnt, 16'd1);
    chk("t1 busy idle", busy, 1'b0);

    // Fill while ALU stalls: one entry at the pins plus four buffered
    ALU_RDY = 0;
    for (int i = 0; i < 5; i++) begin
      set_txn(4'(i + 2), 8'(8'h10 + i), 8'(8'h20 + i), 8'd0);
      in_vld = 1;
      step();
    end
    in_vld = 0;
    chk("t2 in_rdy full", in_rdy, 1'b0);
    chk("t2 act hold", ACT, 1'b1);
    chk("t2 reg_a first", REG_A, 8'h10);
    step(); step(); step();
    chk("t2 no transfer", sent_cnt, 16'd1);
    ALU_RDY = 1;
    for (int i = 0; i < 6; i++) step();
    chk("t3 sent", sent_cnt, 16'd6);
    chk("t3 in_rdy", in_rdy, 1'b1);
    chk("t3 idle", busy, 1'b0);

    // Delay of 3, then one stall cycle before acceptance
    ALU_RDY = 0;
    set_txn(4'd9, 8'hA5, 8'h5A, 8'd3);
    in_vld = 1;
    step();
    in_vld = 0;
    step();
    chk("t4 idle1", ACT, 1'b0);
    chk("t4 busy", busy, 1'b1);
    step();
    chk("t4 idle2", ACT, 1'b0);
    step();
    chk("t4 idle3", ACT, 1'b0);
    step();
    chk("t4 act", ACT, 1'b1);
    chk("t4 reg_a", REG_A, 8'hA5);
    step();
    chk("t4 stall hold", ACT, 1'b1);
    ALU_RDY = 1;
    step();
    chk("t4 sent", sent_cnt, 16'd7);
    chk("t4 act drop", ACT, 1'b0);

    // Reset while issuing with two entries buffered
    ALU_RDY = 0;
    for (int i = 0; i < 3; i++) begin
      set_txn(4'd3, 8'(8'h30 + i), 8'h00, 8'd0);
      in_vld = 1;
      step();
    end
    in_vld = 0;
    chk("t5 pre act", ACT, 1'b1);
    RST = 0;
    step();
    chk("t5 act", ACT, 1'b0);
    chk("t5 busy", busy, 1'b0);
    chk("t5 sent", sent_cnt, 16'd0);
    RST = 1;
    ALU_RDY = 1;
    for (int i = 0; i < 4; i++) step();
    chk("t5 no transfer", sent_cnt, 16'd0);
    chk("t5 still idle", ACT, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      in_vld  = ($urandom_range(0, 1) == 1);
      ALU_RDY = ($urandom_range(0, 9) < 7);
      RST     = ($urandom_range(0, 149) != 0);
      set_txn(4'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 15))
                                          : 8'($urandom_range(0, 3)));
      step();
    end
    in_vld = 0; ALU_RDY = 1; RST = 1;
    for (int i = 0; i < 80; i++) step();
    chk("rand drained", busy, 1'b0);

    // sent_cnt wrap: 65535 streamed transfers, then one more
    RST = 0;
    step();
    RST = 1;
    ALU_RDY = 1;
    cyc = 0;
    while (m_pushes < 65535 && cyc < 70000) begin
      set_txn(4'($urandom), 8'($urandom), 8'($urandom), 8'd0);
      in_vld = 1;
      step();
      cyc++;
    end
    in_vld = 0;
    chk("wrap push budget", m_pushes, 65535);
    for (int i = 0; i < 10; i++) step();
    chk("wrap ffff", sent_cnt, 16'hFFFF);
    set_txn(4'd7, 8'h11, 8'h22, 8'd0);
    in_vld = 1;
    step();
    in_vld = 0;
    for (int i = 0; i < 5; i++) step();
    chk("wrap zero", sent_cnt, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
